// File: rtl/sim_result_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sim_result_monitor
// Purpose  : Watches register-file writebacks for the x26/x27 end-of-test
//            handshake and holds a sticky pass/fail/timeout verdict.
// Revision : 1.0
// ============================================================================
module sim_result_monitor #(
    parameter int REG_WIDTH      = 32,
    parameter int END_REG        = 26,
    parameter int RESULT_REG     = 27,
    parameter int TESTNUM_REG    = 3,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [REG_WIDTH-1:0] wb_data,
    input  logic                 retire,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [REG_WIDTH-1:0] fail_testnum,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          inst_cnt
);

    localparam int SETTLE_W = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [4:0]          END_IDX      = 5'(END_REG);
    localparam logic [4:0]          RESULT_IDX   = 5'(RESULT_REG);
    localparam logic [4:0]          TESTNUM_IDX  = 5'(TESTNUM_REG);
    localparam logic [31:0]         TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD  = SETTLE_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t state, state_next;

    logic [REG_WIDTH-1:0] shadow_testnum;
    logic [REG_WIDTH-1:0] shadow_result;
    logic [REG_WIDTH-1:0] eff_testnum;
    logic [REG_WIDTH-1:0] eff_result;
    logic [SETTLE_W-1:0]  settle_cnt;

    logic active;
    logic wr_valid;
    logic wr_result;
    logic wr_testnum;
    logic end_trigger;
    logic settle_last;
    logic timeout_hit;
    logic next_terminal;

    // x0 is hardwired to zero in the CPU, so its writes never count here.
    always_comb begin
        active      = (state == ST_RUN) || (state == ST_SETTLE);
        wr_valid    = wb_en && (wb_addr != 5'd0);
        wr_result   = wr_valid && (wb_addr == RESULT_IDX);
        wr_testnum  = wr_valid && (wb_addr == TESTNUM_IDX);
        eff_result  = wr_result  ? wb_data : shadow_result;
        eff_testnum = wr_testnum ? wb_data : shadow_testnum;
        end_trigger = (state == ST_RUN) && wr_valid && (wb_addr == END_IDX)
                      && (wb_data == REG_WIDTH'(1));
        settle_last = (state == ST_SETTLE) && (settle_cnt == SETTLE_W'(1));
        timeout_hit = active && (cycle_cnt >= TIMEOUT_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (end_trigger) begin
                    state_next = ST_SETTLE;
                end else if (timeout_hit) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_next = (eff_result == REG_WIDTH'(1)) ? ST_PASS : ST_FAIL;
                end else if (timeout_hit) begin
                    state_next = ST_TIMEOUT;
                end
            end
            default: state_next = state;
        endcase
        next_terminal = (state_next == ST_PASS) || (state_next == ST_FAIL)
                        || (state_next == ST_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            fail_testnum   <= '0;
            cycle_cnt      <= '0;
            inst_cnt       <= '0;
            shadow_testnum <= '0;
            shadow_result  <= '0;
            settle_cnt     <= '0;
        end else begin
            done    <= next_terminal;
            pass    <= (state_next == ST_PASS);
            fail    <= (state_next == ST_FAIL);
            timeout <= (state_next == ST_TIMEOUT);

            if (active) begin
                if (wr_testnum) begin
                    shadow_testnum <= wb_data;
                end
                if (wr_result) begin
                    shadow_result <= wb_data;
                end
                // The timeout edge itself is not counted as a spent cycle.
                if ((state_next != ST_TIMEOUT) && (cycle_cnt != 32'hFFFF_FFFF)) begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                end
                if (retire && (inst_cnt != 32'hFFFF_FFFF)) begin
                    inst_cnt <= inst_cnt + 32'd1;
                end
                if (next_terminal) begin
                    fail_testnum <= eff_testnum;
                end
            end

            if (end_trigger) begin
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sim_result_monitor.md
Name: sim_result_monitor

Overview:
- Consumes the CPU register-file writeback stream. Detects the end-of-test handshake used by the test programs: x26 written to 1 ends the test, then x27 == 1 means pass.
- Produces a registered verdict (pass/fail/timeout) with failing test number, cycle count and retired-instruction count.
- Sits beside the register file, downstream of the writeback stage. The bench and an FPGA LED/UART reporter both read its outputs instead of probing internal registers hierarchically.

Parameters:
- REG_WIDTH, 32, width of writeback data and shadow registers
- END_REG, 26, register index whose write of 1 ends the test
- RESULT_REG, 27, register index holding the pass flag (1 = pass)
- TESTNUM_REG, 3, register index holding the current test number
- SETTLE_CYCLES, 1, cycles waited after the end trigger before sampling the verdict (≥1)
- TIMEOUT_CYCLES, 50000, cycles in RUN/SETTLE before a timeout verdict (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_en  in  1  register-file write enable
- wb_addr  in  5  register-file write index
- wb_data  in  REG_WIDTH  register-file write data
- retire  in  1  one pulse per retired instruction
- done  out  1  verdict reached (sticky)
- pass  out  1  test passed (sticky)
- fail  out  1  test failed, x27 != 1 at sample (sticky)
- timeout  out  1  no end trigger within TIMEOUT_CYCLES (sticky)
- fail_testnum  out  REG_WIDTH  TESTNUM_REG shadow captured at verdict
- cycle_cnt  out  32  cycles spent in RUN/SETTLE
- inst_cnt  out  32  retire pulses counted in RUN/SETTLE

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high and overrides everything. On reset: state=RUN; done/pass/fail/timeout=0; fail_testnum=0; cycle_cnt=0; inst_cnt=0; shadow_testnum=0; shadow_result=0; settle_cnt=0. Reset mid-test or after a verdict returns to RUN and clears everything.
- All outputs are registered. No combinational path from any input to any output.
- Shadow tracking, in RUN and SETTLE only:
  - wb_en && wb_addr==TESTNUM_REG loads shadow_testnum.
  - wb_en && wb_addr==RESULT_REG loads shadow_result.
  - Writes with wb_addr==0 are ignored entirely, even if a parameter is set to 0.
- States: RUN, SETTLE, PASS, FAIL, TIMEOUT.
- RUN:
  - End trigger = wb_en && wb_addr==END_REG && wb_data==1. On the trigger edge go to SETTLE and load settle_cnt=SETTLE_CYCLES.
  - A write of any other value to END_REG is not a trigger.
- SETTLE:
  - Each edge decrements settle_cnt.
  - On the edge where settle_cnt==1, go to PASS if the effective result is 1, else FAIL.
  - Effective result = shadow_result, except when the same edge writes RESULT_REG: then that write's wb_data is used (forwarding).
  - On that edge fail_testnum captures the effective testnum (same forwarding rule). It is captured for PASS too.
  - Further END_REG writes in SETTLE are ignored.
- Verdict latency: trigger sampled at edge N, verdict visible after edge N+SETTLE_CYCLES.
- Timeout:
  - cycle_cnt increments every edge in RUN/SETTLE.
  - When cycle_cnt==TIMEOUT_CYCLES-1 at an edge, go to TIMEOUT; fail_testnum captures the effective testnum.
  - Same edge as an end trigger (RUN), or as settle completion (SETTLE): the trigger/verdict wins and timeout is not flagged.
  - A timeout while in SETTLE with settle_cnt>1 goes to TIMEOUT.
- Terminal states (PASS/FAIL/TIMEOUT): sticky until rst.
  - done=1, exactly one of pass/fail/timeout=1.
  - cycle_cnt, inst_cnt and shadows freeze; inputs are ignored.
- inst_cnt increments on retire in RUN/SETTLE, including on the verdict edge.
- Both counters saturate at 2^32-1 and never wrap.
- Expected RTL size: roughly 150–250 lines.

Test Plan:
- Pass: write x3=5, x27=1, then x26=1 at edge N → after edge N+1: done=1, pass=1, fail=0, fail_testnum=5.
- Fail with late result: write x3=7, x27=0, x26=1, then x27=1 on the following edge (forwarded) → pass=1. Repeat with x27=2 → fail=1, fail_testnum=7.
- Non-trigger and x0 writes: write x26=2, and write x0 with END_REG=0 → no state change; a later x26=1 → verdict as normal.
- Timeout with TIMEOUT_CYCLES=20 and no trigger → after edge 20: timeout=1, done=1, cycle_cnt=19. Trigger on the timeout edge → SETTLE entered, no timeout flag.
- Counters: 10 retire pulses before the trigger, 1 in SETTLE, 3 after the verdict → inst_cnt=11 and frozen. Writes after the verdict do not change fail_testnum.
- Reset: assert rst for 1 cycle while in SETTLE, and again while in PASS → all outputs 0, state RUN. Next trigger evaluates only writes made after reset.
